// File: rtl/fabric_warmboot_ctrl.sv
// fabric_warmboot_ctrl
// Warmboot sequencer for the southern warmboot tile. The fabric-routed BOOT
// trigger and its SLOT selection are synchronised and qualified here. The
// qualified request goes to the configuration controller over req/ack, and a
// timed fabric reset pulse follows an accepted request. Range, timeout and
// controller-reject conditions are kept as sticky error flags.
`timescale 1ns/1ps

module fabric_warmboot_ctrl #(
  parameter int SLOT_WIDTH     = 4,
  parameter int NUM_SLOTS      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RESET_CYCLES   = 16
) (
  input  logic                  UserCLK,
  input  logic                  resetn,
  input  logic [SLOT_WIDTH-1:0] SLOT,
  input  logic                  BOOT,
  input  logic                  boot_ack,
  input  logic                  boot_err,
  input  logic                  err_clr,
  output logic                  boot_req,
  output logic [SLOT_WIDTH-1:0] boot_slot,
  output logic                  fabric_reset_n,
  output logic                  busy,
  output logic [SLOT_WIDTH-1:0] last_slot,
  output logic [2:0]            err
);

  // Counter widths: $clog2 of the limit, never narrower than one bit.
  localparam int HOLD_W = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RST_W  = (RESET_CYCLES   > 1) ? $clog2(RESET_CYCLES)   : 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RST_W-1:0]  RST_MAX  = RST_W'(RESET_CYCLES - 1);
  // With the timeout disabled the terminal value is never consulted.
  localparam logic [TO_W-1:0]   TO_MAX   =
    TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUAL  = 3'd1,
    REQ   = 3'd2,
    RST   = 3'd3,
    REARM = 3'd4
  } state_t;

  // Error bit positions inside err.
  localparam int ERR_RANGE   = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_CFG     = 2;

  // Synchroniser chains.
  logic [SYNC_STAGES-1:0] boot_sync_q;
  logic [SLOT_WIDTH-1:0]  slot_sync_q [SYNC_STAGES];
  logic                   boot_s;
  logic [SLOT_WIDTH-1:0]  slot_s;

  // Sequencer state.
  state_t                 state_q, state_d;
  logic [SLOT_WIDTH-1:0]  cap_q, cap_d;
  logic [HOLD_W-1:0]      hcnt_q, hcnt_d;
  logic [TO_W-1:0]        tcnt_q, tcnt_d;
  logic [RST_W-1:0]       rcnt_q, rcnt_d;
  logic [SLOT_WIDTH-1:0]  last_q, last_d;
  logic [2:0]             err_q, err_d;
  logic [2:0]             err_set;
  logic                   rel_q;

  logic                   cap_in_range;
  logic                   timeout_hit;

  assign boot_s = boot_sync_q[SYNC_STAGES-1];
  assign slot_s = slot_sync_q[SYNC_STAGES-1];

  // Slot index compared at 32 bits so NUM_SLOTS = 2**SLOT_WIDTH is representable.
  assign cap_in_range = (32'(cap_q) < NUM_SLOTS);
  assign timeout_hit  = TO_EN && (tcnt_q == TO_MAX);

  // Shift BOOT and SLOT through the synchroniser flops.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      boot_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        slot_sync_q[i] <= '0;
      end
    end else begin
      boot_sync_q[0] <= BOOT;
      slot_sync_q[0] <= SLOT;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        boot_sync_q[i] <= boot_sync_q[i-1];
        slot_sync_q[i] <= slot_sync_q[i-1];
      end
    end
  end

  // State, counters, captured slot and sticky errors.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cap_q   <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      rcnt_q  <= '0;
      last_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      rcnt_q  <= rcnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Fabric reset release: held low through resetn, freed on the first edge after.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= 1'b1;
    end
  end

  // Next-state logic: qualify the trigger, run the handshake and reset pulse.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    err_set = '0;

    case (state_q)
      IDLE: begin
        if (boot_s) begin
          cap_d   = slot_s;
          hcnt_d  = '0;
          state_d = QUAL;
        end
      end

      QUAL: begin
        if (!boot_s) begin
          // Trigger vanished before the hold window expired: a glitch.
          state_d = IDLE;
        end else if (slot_s != cap_q) begin
          // Slot moved: restart the stability window on the new value.
          cap_d  = slot_s;
          hcnt_d = '0;
        end else if (hcnt_q == HOLD_MAX) begin
          if (!cap_in_range) begin
            err_set[ERR_RANGE] = 1'b1;
            state_d            = REARM;
          end else begin
            tcnt_d  = '0;
            state_d = REQ;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      REQ: begin
        // Reject beats accept; accept beats timeout.
        if (boot_err) begin
          err_set[ERR_CFG] = 1'b1;
          state_d          = REARM;
        end else if (boot_ack) begin
          last_d  = cap_q;
          rcnt_d  = '0;
          state_d = RST;
        end else if (timeout_hit) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_d              = REARM;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      RST: begin
        if (rcnt_q == RST_MAX) begin
          state_d = REARM;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end

      REARM: begin
        // A held trigger must drop before another boot can start.
        if (!boot_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A set event on the same edge as a clear keeps its bit.
    err_d = (err_clr ? 3'b000 : err_q) | err_set;
  end

  // Outputs decoded straight from registered state so resetn clears them at once.
  always_comb begin
    boot_req       = (state_q == REQ);
    boot_slot      = (state_q == REQ) ? cap_q : '0;
    busy           = (state_q != IDLE);
    fabric_reset_n = rel_q && (state_q != RST);
    last_slot      = last_q;
    err            = err_q;
  end

endmodule

// File: tb/tb_fabric_warmboot_ctrl.sv
// Directed bench for fabric_warmboot_ctrl with NUM_SLOTS=12 and
// TIMEOUT_CYCLES=20; all other parameters at their defaults.
`timescale 1ns/1ps

module tb_fabric_warmboot_ctrl;

  logic       UserCLK;
  logic       resetn;
  logic [3:0] SLOT;
  logic       BOOT;
  logic       boot_ack;
  logic       boot_err;
  logic       err_clr;
  logic       boot_req;
  logic [3:0] boot_slot;
  logic       fabric_reset_n;
  logic       busy;
  logic [3:0] last_slot;
  logic [2:0] err;

  int n_assert = 0;
  int n_fail   = 0;
  bit saw_req  = 1'b0;
  bit saw_rst  = 1'b0;

  fabric_warmboot_ctrl #(
    .SLOT_WIDTH     (4),
    .NUM_SLOTS      (12),
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (8),
    .TIMEOUT_CYCLES (20),
    .RESET_CYCLES   (16)
  ) dut (
    .UserCLK        (UserCLK),
    .resetn         (resetn),
    .SLOT           (SLOT),
    .BOOT           (BOOT),
    .boot_ack       (boot_ack),
    .boot_err       (boot_err),
    .err_clr        (err_clr),
    .boot_req       (boot_req),
    .boot_slot      (boot_slot),
    .fabric_reset_n (fabric_reset_n),
    .busy           (busy),
    .last_slot      (last_slot),
    .err            (err)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 ns and note any request or reset pulse.
  task automatic tick();
    @(posedge UserCLK);
    #1;
    if (boot_req === 1'b1)       saw_req = 1'b1;
    if (fabric_reset_n === 1'b0) saw_rst = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    resetn   = 1'b0;
    SLOT     = 4'd0;
    BOOT     = 1'b0;
    boot_ack = 1'b0;
    boot_err = 1'b0;
    err_clr  = 1'b0;

    // Reset values
    #2;
    chk("rst boot_req",  32'(boot_req), 32'd0);
    chk("rst boot_slot", 32'(boot_slot), 32'd0);
    chk("rst busy",      32'(busy), 32'd0);
    chk("rst last_slot", 32'(last_slot), 32'd0);
    chk("rst err",       32'(err), 32'd0);
    chk("rst frn",       32'(fabric_reset_n), 32'd0);
    @(posedge UserCLK); @(posedge UserCLK); #1;
    chk("rst frn held through edges", 32'(fabric_reset_n), 32'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    tick();
    chk("rst frn release", 32'(fabric_reset_n), 32'd1);

    // Clean boot, SLOT=5: request on edge 11, ack on edge 14
    SLOT = 4'd5; BOOT = 1'b1;
    ticks(10);
    chk("clean no req e10", 32'(boot_req), 32'd0);
    chk("clean busy e10",   32'(busy), 32'd1);
    tick();
    chk("clean req e11",  32'(boot_req), 32'd1);
    chk("clean slot e11", 32'(boot_slot), 32'd5);
    ticks(2);
    boot_ack = 1'b1;
    tick();
    boot_ack = 1'b0;
    chk("clean req drop e14", 32'(boot_req), 32'd0);
    chk("clean frn low e14",  32'(fabric_reset_n), 32'd0);
    chk("clean slot zero",    32'(boot_slot), 32'd0);
    ticks(15);
    chk("clean frn low e29",  32'(fabric_reset_n), 32'd0);
    tick();
    chk("clean frn high e30", 32'(fabric_reset_n), 32'd1);
    chk("clean last_slot",    32'(last_slot), 32'd5);
    saw_req = 1'b0;
    ticks(20);
    chk("rearm no retrigger", 32'(saw_req), 32'd0);
    chk("rearm busy",         32'(busy), 32'd1);
    BOOT = 1'b0;
    ticks(3);
    chk("rearm to idle", 32'(busy), 32'd0);
    chk("clean err",     32'(err), 32'd0);

    // Ack outside REQ is ignored
    boot_ack = 1'b1;
    tick();
    boot_ack = 1'b0;
    chk("idle ack frn",  32'(fabric_reset_n), 32'd1);
    chk("idle ack busy", 32'(busy), 32'd0);
    chk("idle ack last", 32'(last_slot), 32'd5);

    // Five-cycle BOOT glitch
    SLOT = 4'd2; BOOT = 1'b1; saw_req = 1'b0;
    ticks(5);
    chk("glitch busy", 32'(busy), 32'd1);
    BOOT = 1'b0;
    ticks(12);
    chk("glitch no req", 32'(saw_req), 32'd0);
    chk("glitch err",    32'(err), 32'd0);
    chk("glitch idle",   32'(busy), 32'd0);

    // SLOT 3->7 mid-QUAL: window restarts at edge 8, request on edge 16
    SLOT = 4'd3; BOOT = 1'b1;
    ticks(5);
    SLOT = 4'd7;
    ticks(10);
    chk("restart no req e15", 32'(boot_req), 32'd0);
    tick();
    chk("restart req e16",  32'(boot_req), 32'd1);
    chk("restart slot e16", 32'(boot_slot), 32'd7);

    // No ack: timeout 20 edges after the request rose (edge 36)
    ticks(19);
    chk("timeout req e35", 32'(boot_req), 32'd1);
    chk("timeout err e35", 32'(err), 32'd0);
    tick();
    chk("timeout req drop", 32'(boot_req), 32'd0);
    chk("timeout err",      32'(err), 32'b010);
    chk("timeout frn",      32'(fabric_reset_n), 32'd1);
    BOOT = 1'b0;
    ticks(3);

    // SLOT=13 with NUM_SLOTS=12: range error accumulates with timeout bit
    SLOT = 4'd13; BOOT = 1'b1; saw_req = 1'b0;
    ticks(10);
    chk("range err e10", 32'(err), 32'b010);
    tick();
    chk("range err e11", 32'(err), 32'b011);
    chk("range busy",    32'(busy), 32'd1);
    ticks(5);
    chk("range no req", 32'(saw_req), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    BOOT = 1'b0;
    ticks(3);

    // Range error on the same edge as err_clr keeps bit 0
    SLOT = 4'd13; BOOT = 1'b1;
    ticks(10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("range vs clr", 32'(err), 32'b001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr after range", 32'(err), 32'd0);
    BOOT = 1'b0;
    ticks(3);

    // Ack on the timeout edge (edge 31): normal reset pulse, no error
    SLOT = 4'd4; BOOT = 1'b1;
    ticks(11);
    chk("expiry req e11", 32'(boot_req), 32'd1);
    ticks(19);
    chk("expiry req e30", 32'(boot_req), 32'd1);
    boot_ack = 1'b1;
    tick();
    boot_ack = 1'b0;
    chk("expiry req drop", 32'(boot_req), 32'd0);
    chk("expiry frn low",  32'(fabric_reset_n), 32'd0);
    chk("expiry err",      32'(err), 32'd0);
    chk("expiry last",     32'(last_slot), 32'd4);
    ticks(15);
    chk("expiry frn e46", 32'(fabric_reset_n), 32'd0);
    tick();
    chk("expiry frn e47", 32'(fabric_reset_n), 32'd1);
    BOOT = 1'b0;
    ticks(3);

    // Ack and err together: cfg error, no reset pulse
    SLOT = 4'd6; BOOT = 1'b1;
    ticks(11);
    boot_ack = 1'b1; boot_err = 1'b1; saw_rst = 1'b0;
    tick();
    boot_ack = 1'b0; boot_err = 1'b0;
    chk("ackerr req drop", 32'(boot_req), 32'd0);
    chk("ackerr err",      32'(err), 32'b100);
    chk("ackerr last",     32'(last_slot), 32'd4);
    ticks(5);
    chk("ackerr no pulse", 32'(saw_rst), 32'd0);
    chk("ackerr busy",     32'(busy), 32'd1);
    BOOT = 1'b0;
    ticks(3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ackerr clr", 32'(err), 32'd0);

    // resetn during REQ
    SLOT = 4'd9; BOOT = 1'b1;
    ticks(12);
    chk("mid req up", 32'(boot_req), 32'd1);
    #2;
    resetn = 1'b0; BOOT = 1'b0;
    #1;
    chk("req rst boot_req", 32'(boot_req), 32'd0);
    chk("req rst slot",     32'(boot_slot), 32'd0);
    chk("req rst busy",     32'(busy), 32'd0);
    chk("req rst frn",      32'(fabric_reset_n), 32'd0);
    chk("req rst last",     32'(last_slot), 32'd0);
    chk("req rst err",      32'(err), 32'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    tick();
    chk("req rst frn release", 32'(fabric_reset_n), 32'd1);
    chk("req rst idle",        32'(busy), 32'd0);

    // resetn during RST
    SLOT = 4'd2; BOOT = 1'b1;
    ticks(11);
    boot_ack = 1'b1;
    tick();
    boot_ack = 1'b0;
    ticks(2);
    chk("mid rst frn",  32'(fabric_reset_n), 32'd0);
    chk("mid rst last", 32'(last_slot), 32'd2);
    #2;
    resetn = 1'b0; BOOT = 1'b0;
    #1;
    chk("rst rst busy", 32'(busy), 32'd0);
    chk("rst rst last", 32'(last_slot), 32'd0);
    chk("rst rst frn",  32'(fabric_reset_n), 32'd0);
    @(posedge UserCLK); #1;
    chk("rst rst frn held", 32'(fabric_reset_n), 32'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    tick();
    chk("rst rst frn release", 32'(fabric_reset_n), 32'd1);
    chk("rst rst idle",        32'(busy), 32'd0);
    chk("rst rst no req",      32'(boot_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
